rx78_cart_loader: RTL

//  Sequencer between the MiSTer ioctl download stream and the RX-78 cartridge/ext-RAM/VRAM arrays.

---
 rtl/rx78_cart_loader_if.sv | 33 +++
 rtl/rx78_cart_loader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rx78_cart_loader_if.sv
// Bus bundle between the ioctl download stream and the cart loader.
// master: download source and array side. slave: rx78_cart_loader.
interface rx78_cart_loader_if;
    logic        upload;
    logic [7:0]  upload_index;
    logic        upload_wr;
    logic [24:0] upload_addr;
    logic [7:0]  upload_data;
    logic [7:0]  wr_data;
    logic [12:0] cart_addr;
    logic        cart1_we;
    logic        cart2_we;
    logic [14:0] ext_addr;
    logic        ext_we;
    logic [12:0] vram_addr;
    logic        vram_we;
    logic        cpu_reset;
    logic        ext_map;
    logic        overflow;
    logic        busy;

    modport master (
        output upload, upload_index, upload_wr, upload_addr, upload_data,
        input  wr_data, cart_addr, cart1_we, cart2_we, ext_addr, ext_we,
        input  vram_addr, vram_we, cpu_reset, ext_map, overflow, busy
    );

    modport slave (
        input  upload, upload_index, upload_wr, upload_addr, upload_data,
        output wr_data, cart_addr, cart1_we, cart2_we, ext_addr, ext_we,
        output vram_addr, vram_we, cpu_reset, ext_map, overflow, busy
    );
endinterface

// File: rtl/rx78_cart_loader.sv
// RX-78 cart loader: routes download bytes to cart1/cart2/ext RAM, pads cart space
// with 0xFF, clears VRAM, holds the Z80 in reset. Ports: clk, reset_n, io_bus (slave).
module rx78_cart_loader #(
    parameter logic [7:0] CART_INDEX = 8'd1,
    parameter int         RESET_HOLD = 16,
    parameter int         VRAM_WORDS = 8192,
    parameter int         MAX_BYTES  = 49152
) (
    input  logic               clk,
    input  logic               reset_n,
    rx78_cart_loader_if.slave  io_bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PAD, S_CLEAR, S_HOLD
    } state_t;

    localparam int          HW      = $clog2(RESET_HOLD + 1);
    localparam logic [12:0] V_LAST  = 13'(VRAM_WORDS - 1);
    localparam logic [24:0] MAX_OFF = 25'(MAX_BYTES);

    state_t        r_state;
    state_t        w_state_nx;
    logic          r_upload_d;
    logic [16:0]   r_count;
    logic [12:0]   r_vptr;
    logic [HW-1:0] r_hold;
    logic [7:0]    r_wr_data;
    logic [12:0]   r_cart_addr;
    logic          r_cart1_we;
    logic          r_cart2_we;
    logic [14:0]   r_ext_addr;
    logic          r_ext_we;
    logic [12:0]   r_vram_addr;
    logic          r_vram_we;
    logic          r_cpu_reset;
    logic          r_ext_map;
    logic          r_ovf;

    logic          w_sel;
    logic          w_restart;
    logic          w_wr;
    logic          w_in_range;
    logic [16:0]   w_off1;
    logic [14:0]   w_ext_off;
    logic          w_pad_go;
    logic          w_enter_load;

    assign w_sel      = io_bus.upload_index == CART_INDEX;
    // Only a fresh rising edge restarts; a level left high must not retrigger
    assign w_restart  = io_bus.upload & ~r_upload_d & w_sel;
    assign w_wr       = (r_state == S_LOAD) & io_bus.upload_wr & w_sel;
    assign w_in_range = io_bus.upload_addr < MAX_OFF;
    assign w_off1     = {1'b0, io_bus.upload_addr[15:0]} + 17'd1;
    assign w_ext_off  = io_bus.upload_addr[14:0] - 15'h4000;
    assign w_pad_go   = r_count < 17'h4000;
    assign w_enter_load = (w_state_nx == S_LOAD) && (r_state != S_LOAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:  if (io_bus.upload && w_sel) w_state_nx = S_LOAD;
            S_LOAD:  if (!io_bus.upload) w_state_nx = S_PAD;
            S_PAD: begin
                if (w_restart)      w_state_nx = S_LOAD;
                else if (!w_pad_go) w_state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                if (w_restart)             w_state_nx = S_LOAD;
                else if (r_vptr == V_LAST) w_state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (w_restart)              w_state_nx = S_LOAD;
                else if (r_hold == HW'(1))  w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_upload_d  <= 1'b0;
            r_count     <= '0;
            r_vptr      <= '0;
            r_hold      <= '0;
            r_wr_data   <= '0;
            r_cart_addr <= '0;
            r_cart1_we  <= 1'b0;
            r_cart2_we  <= 1'b0;
            r_ext_addr  <= '0;
            r_ext_we    <= 1'b0;
            r_vram_addr <= '0;
            r_vram_we   <= 1'b0;
            r_cpu_reset <= 1'b0;
            r_ext_map   <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_upload_d <= io_bus.upload;
            r_cart1_we <= 1'b0;
            r_cart2_we <= 1'b0;
            r_ext_we   <= 1'b0;
            r_vram_we  <= 1'b0;
            unique case (r_state)
                S_LOAD: begin
                    if (w_wr && !w_in_range) begin
                        r_ovf <= 1'b1;
                    end else if (w_wr) begin
                        r_wr_data   <= io_bus.upload_data;
                        r_cart_addr <= io_bus.upload_addr[12:0];
                        r_ext_addr  <= w_ext_off;
                        r_cart1_we  <= io_bus.upload_addr < 25'h2000;
                        r_cart2_we  <= (io_bus.upload_addr >= 25'h2000) &&
                                       (io_bus.upload_addr < 25'h4000);
                        r_ext_we    <= io_bus.upload_addr >= 25'h4000;
                        if (w_off1 > r_count) r_count <= w_off1;
                    end
                end
                S_PAD: begin
                    // count doubles as the pad pointer; it ends at 0x4000
                    if (w_state_nx == S_PAD) begin
                        r_wr_data   <= 8'hFF;
                        r_cart_addr <= r_count[12:0];
                        r_cart1_we  <= ~r_count[13];
                        r_cart2_we  <= r_count[13];
                        r_count     <= r_count + 17'd1;
                    end else if (w_state_nx == S_CLEAR) begin
                        r_ext_map <= r_count > 17'h4000;
                        r_vptr    <= '0;
                    end
                end
                S_CLEAR: begin
                    if (w_state_nx != S_LOAD) begin
                        r_vram_we   <= 1'b1;
                        r_vram_addr <= r_vptr;
                        r_vptr      <= r_vptr + 13'd1;
                    end
                    if (w_state_nx == S_HOLD) begin
                        r_vptr <= '0;
                        r_hold <= HW'(RESET_HOLD);
                    end
                end
                S_HOLD: begin
                    if (w_state_nx != S_LOAD) r_hold <= r_hold - HW'(1);
                    if (w_state_nx == S_IDLE) r_cpu_reset <= 1'b0;
                end
                default: ;
            endcase
            if (w_enter_load) begin
                r_count     <= '0;
                r_ovf       <= 1'b0;
                r_ext_map   <= 1'b0;
                r_vptr      <= '0;
                r_cpu_reset <= 1'b1;
            end
        end
    end

    assign io_bus.wr_data   = r_wr_data;
    assign io_bus.cart_addr = r_cart_addr;
    assign io_bus.cart1_we  = r_cart1_we;
    assign io_bus.cart2_we  = r_cart2_we;
    assign io_bus.ext_addr  = r_ext_addr;
    assign io_bus.ext_we    = r_ext_we;
    assign io_bus.vram_addr = r_vram_addr;
    assign io_bus.vram_we   = r_vram_we;
    assign io_bus.cpu_reset = r_cpu_reset;
    assign io_bus.ext_map   = r_ext_map;
    assign io_bus.overflow  = r_ovf;
    assign io_bus.busy      = r_state != S_IDLE;
endmodule
